nla_poly_sequencer: RTL and testbench

Sequencer that evaluates a degree-N polynomial in one float32 operand by Horner's rule on the shared floating-point multiply-add unit. It holds the coefficient table (e.g. Taylor terms 1/k!), accepts one input sample at a time, and issues one `acc*x + c[k]` operation per step. It returns the final sum with a valid/ready handshake. It sits between the activation front-end (SeLU/sigmoid/swish/GELU input streams) and the `mac` datapath.

---
 rtl/nla_poly_sequencer_if.sv | 32 +++
 rtl/nla_poly_sequencer.sv | 129 ++++++++++++
 tb/tb_nla_poly_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nla_poly_sequencer_if.sv
// rtl/nla_poly_sequencer_if.sv - sample, multiply-add and result handshakes of the polynomial sequencer
interface nla_poly_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  // input sample stream
  logic                  x_valid_i;
  logic                  x_ready_o;
  logic [DATA_WIDTH-1:0] x_data_i;
  // multiply-add unit request/response
  logic                  mac_req_o;
  logic [DATA_WIDTH-1:0] mac_a_o;
  logic [DATA_WIDTH-1:0] mac_b_o;
  logic [DATA_WIDTH-1:0] mac_c_o;
  logic                  mac_valid_i;
  logic [DATA_WIDTH-1:0] mac_res_i;
  // result stream
  logic                  y_valid_o;
  logic                  y_ready_i;
  logic [DATA_WIDTH-1:0] y_data_o;

  // sequencer side
  modport master (
    input  x_valid_i, x_data_i, mac_valid_i, mac_res_i, y_ready_i,
    output x_ready_o, mac_req_o, mac_a_o, mac_b_o, mac_c_o, y_valid_o, y_data_o
  );

  // front-end / datapath side
  modport slave (
    output x_valid_i, x_data_i, mac_valid_i, mac_res_i, y_ready_i,
    input  x_ready_o, mac_req_o, mac_a_o, mac_b_o, mac_c_o, y_valid_o, y_data_o
  );
endinterface

// File: rtl/nla_poly_sequencer.sv
// rtl/nla_poly_sequencer.sv - Horner-rule polynomial sequencer driving a shared float32 multiply-add unit
module nla_poly_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_we_i,
  input  logic [ADDR_LINES-1:0] cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic                  cfg_order_we_i,
  input  logic [ADDR_LINES-1:0] cfg_order_i,
  output logic                  cfg_err_o,
  output logic                  busy_o,
  nla_poly_sequencer_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] x_reg;
  logic [ADDR_LINES-1:0] k;
  logic [ADDR_LINES-1:0] order;
  logic                  cfg_err_q;
  logic                  x_ready_q;
  logic                  busy_q;
  logic                  mac_req_q;
  logic [DATA_WIDTH-1:0] mac_c_q;
  logic                  y_valid_q;

  logic [DATA_WIDTH-1:0] coef_mem [2**ADDR_LINES];

  // NaN samples skip the Horner loop and are returned unchanged
  logic x_is_nan;
  assign x_is_nan = (bus.x_data_i[30:23] == 8'hFF) && (bus.x_data_i[22:0] != '0);

  // coefficient table has no reset; writes only land while idle
  always_ff @(posedge clk_i) begin
    if (cfg_we_i && (state == S_IDLE)) begin
      coef_mem[cfg_addr_i] <= cfg_data_i;
    end
  end

  // sequencer FSM; each next-state branch also loads the outputs of the state it enters
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      acc       <= '0;
      x_reg     <= '0;
      k         <= '0;
      order     <= '0;
      cfg_err_q <= 1'b0;
      x_ready_q <= 1'b1;
      busy_q    <= 1'b0;
      mac_req_q <= 1'b0;
      mac_c_q   <= '0;
      y_valid_q <= 1'b0;
    end else begin
      cfg_err_q <= (cfg_we_i | cfg_order_we_i) & (state != S_IDLE);
      mac_req_q <= 1'b0;
      mac_c_q   <= '0;
      case (state)
        S_IDLE: begin
          if (cfg_order_we_i) begin
            order <= cfg_order_i;
          end
          if (bus.x_valid_i && x_ready_q) begin
            x_reg     <= bus.x_data_i;
            k         <= order;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            if (x_is_nan) begin
              acc       <= bus.x_data_i;
              y_valid_q <= 1'b1;
              state     <= S_OUT;
            end else if (order == '0) begin
              acc       <= coef_mem[order];
              y_valid_q <= 1'b1;
              state     <= S_OUT;
            end else begin
              acc       <= coef_mem[order];
              mac_req_q <= 1'b1;
              mac_c_q   <= coef_mem[order - ADDR_LINES'(1)];
              state     <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          k     <= k - ADDR_LINES'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mac_valid_i) begin
            acc <= bus.mac_res_i;
            if (k == '0) begin
              y_valid_q <= 1'b1;
              state     <= S_OUT;
            end else begin
              mac_req_q <= 1'b1;
              mac_c_q   <= coef_mem[k - ADDR_LINES'(1)];
              state     <= S_ISSUE;
            end
          end
        end
        S_OUT: begin
          if (bus.y_ready_i) begin
            y_valid_q <= 1'b0;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cfg_err_o     = cfg_err_q;
  assign busy_o        = busy_q;
  assign bus.x_ready_o = x_ready_q;
  assign bus.mac_req_o = mac_req_q;
  assign bus.mac_a_o   = mac_req_q ? acc : '0;
  assign bus.mac_b_o   = mac_req_q ? x_reg : '0;
  assign bus.mac_c_o   = mac_c_q;
  assign bus.y_valid_o = y_valid_q;
  assign bus.y_data_o  = y_valid_q ? acc : '0;

endmodule

// File: tb/tb_nla_poly_sequencer.sv
// tb/tb_nla_poly_sequencer.sv - self-checking bench for nla_poly_sequencer with a fixed-latency multiply-add model
module tb_nla_poly_sequencer;

  localparam int MAC_L = 3;

  logic        clk_i;
  logic        rstn_i;
  logic        cfg_we_i;
  logic [4:0]  cfg_addr_i;
  logic [31:0] cfg_data_i;
  logic        cfg_order_we_i;
  logic [4:0]  cfg_order_i;
  logic        cfg_err_o;
  logic        busy_o;

  nla_poly_sequencer_if #(.DATA_WIDTH(32)) bus ();

  nla_poly_sequencer #(.DATA_WIDTH(32), .ADDR_LINES(5)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .cfg_we_i       (cfg_we_i),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_data_i     (cfg_data_i),
    .cfg_order_we_i (cfg_order_we_i),
    .cfg_order_i    (cfg_order_i),
    .cfg_err_o      (cfg_err_o),
    .busy_o         (busy_o),
    .bus            (bus.master)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cnt = 0;
  int err_cnt = 0;

  logic [31:0] coef [32];
  logic [31:0] sb_q [$];
  logic [31:0] c_q [$];
  logic [31:0] cur_x;
  logic [31:0] last_y;
  int t0, reqs0, exp_reqs, exp_lat;

  typedef struct {
    int          due;
    logic [31:0] res;
  } mac_job_t;
  mac_job_t mq [$];

  typedef struct {
    string       name;
    logic [31:0] x;
    int          n;
    logic [31:0] y;
  } vec_t;
  vec_t vecs [7];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == '0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [23:0] m;
    logic [7:0]  e8;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'd0};
    m  = {1'b0, d[51:29]};
    e8 = 8'(d[62:52] - 11'd896);
    if (d[28] && ((|d[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) begin
      m  = '0;
      e8 = e8 + 8'd1;
    end
    return {d[63], e8, m[22:0]};
  endfunction

  function automatic logic [31:0] fma(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return r2f(f2r(a) * f2r(b) + f2r(c));
  endfunction

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  function automatic logic [31:0] horner(input logic [31:0] x, input int n);
    logic [31:0] a;
    if (is_nan(x)) return x;
    a = coef[n];
    for (int k = n - 1; k >= 0; k--) a = fma(a, x, coef[k]);
    return a;
  endfunction

  // multiply-add model: result returned MAC_L cycles after the request, checks operand order
  always @(negedge clk_i) begin
    logic [31:0] e;
    mac_job_t    j;
    if (cfg_err_o) err_cnt++;
    if (bus.mac_req_o) begin
      req_cnt++;
      mq.push_back('{cyc + MAC_L, fma(bus.mac_a_o, bus.mac_b_o, bus.mac_c_o)});
      chk("mac_b", bus.mac_b_o, cur_x);
      if (c_q.size() == 0) begin
        chk("mac_unexpected_req", 32'd1, 32'd0);
      end else begin
        e = c_q.pop_front();
        chk("mac_c_order", bus.mac_c_o, e);
      end
    end
    if (mq.size() > 0 && mq[0].due == cyc) begin
      j = mq.pop_front();
      bus.mac_valid_i = 1'b1;
      bus.mac_res_i   = j.res;
    end else begin
      bus.mac_valid_i = 1'b0;
      bus.mac_res_i   = '0;
    end
  end

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
  endtask

  task automatic cfg_order(input int n);
    @(negedge clk_i);
    cfg_order_we_i = 1'b1; cfg_order_i = 5'(n);
    @(negedge clk_i);
    cfg_order_we_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] x, input int n, input logic [31:0] y_exp);
    bit skip;
    skip = is_nan(x) || (n == 0);
    sb_q.push_back(y_exp);
    if (!skip) for (int k = n - 1; k >= 0; k--) c_q.push_back(coef[k]);
    exp_reqs = skip ? 0 : n;
    exp_lat  = skip ? 1 : 1 + n * (MAC_L + 1);
    @(negedge clk_i);
    cur_x = x;
    bus.x_valid_i = 1'b1; bus.x_data_i = x;
    t0 = cyc; reqs0 = req_cnt;
    @(negedge clk_i);
    bus.x_valid_i = 1'b0; bus.x_data_i = '0;
  endtask

  task automatic finish_sample(input string name);
    int g;
    logic [31:0] e;
    g = 0;
    while (!bus.y_valid_o && g < 3000) begin
      @(negedge clk_i);
      g++;
    end
    if (!bus.y_valid_o) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEADBEEF;
      last_y = bus.y_data_o;
      chk({name, "_y"}, bus.y_data_o, e);
    end
    chk({name, "_reqs"}, 32'(req_cnt - reqs0), 32'(exp_reqs));
    chk({name, "_c_left"}, 32'(c_q.size()), 32'd0);
  endtask

  initial begin
    real f;
    int  g, err0;
    bit  ok;
    logic [31:0] held;

    rstn_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    cfg_order_we_i = 1'b0; cfg_order_i = '0;
    bus.x_valid_i = 1'b0; bus.x_data_i = '0; bus.y_ready_i = 1'b1;
    cur_x = '0; last_y = '0;
    for (int i = 0; i < 32; i++) coef[i] = '0;

    repeat (3) @(negedge clk_i);
    chk("rst_x_ready", 32'(bus.x_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_y_valid", 32'(bus.y_valid_o), 32'd0);
    chk("rst_y_data", bus.y_data_o, 32'd0);
    chk("rst_mac_req", 32'(bus.mac_req_o), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err_o), 32'd0);
    rstn_i = 1'b1;

    // Taylor terms 1/k!
    f = 1.0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) f = f / k;
      coef[k] = r2f(f);
      cfg_write(5'(k), coef[k]);
    end
    chk("cfg_no_err_idle", 32'(err_cnt), 32'd0);

    // order register resets to zero, so this returns c[0]
    send(32'h40400000, 0, coef[0]);
    finish_sample("order_reset");

    vecs[0] = '{"exp1",   32'h3F800000, 15, 32'h0};
    vecs[1] = '{"order0", 32'hC0A00000, 0,  32'h0};
    vecs[2] = '{"nan",    32'h7F900000, 15, 32'h0};
    vecs[3] = '{"half3",  32'h3F000000, 3,  32'h0};
    vecs[4] = '{"two1",   32'h40000000, 1,  32'h0};
    vecs[5] = '{"neg4",   32'hBF800000, 4,  32'h0};
    vecs[6] = '{"five5",  32'h40A00000, 5,  32'h0};
    for (int i = 0; i < 7; i++) vecs[i].y = horner(vecs[i].x, vecs[i].n);
    chk("order0_is_c0", vecs[1].y, 32'h3F800000);
    chk("nan_passthrough_model", vecs[2].y, 32'h7F900000);

    for (int i = 0; i < 7; i++) begin
      cfg_order(vecs[i].n);
      send(vecs[i].x, vecs[i].n, vecs[i].y);
      finish_sample(vecs[i].name);
      if (i == 0) begin
        g = int'(last_y) - int'(32'h402DF854);
        checks++;
        if (g > 2 || g < -2) begin
          errors++;
          $display("FAIL exp1_ulp: got %h expected 402df854 +-2ulp", last_y);
        end
      end
    end

    // backpressure: hold y_ready low in OUT, then back-to-back sample
    cfg_order(2);
    bus.y_ready_i = 1'b0;
    send(32'h40000000, 2, horner(32'h40000000, 2));
    g = 0;
    while (!bus.y_valid_o && g < 3000) begin
      @(negedge clk_i);
      g++;
    end
    chk("bp_valid_rise", 32'(bus.y_valid_o), 32'd1);
    held = bus.y_data_o;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (bus.y_valid_o !== 1'b1 || bus.y_data_o !== held || bus.x_ready_o !== 1'b0) ok = 1'b0;
    end
    chk("bp_stable", 32'(ok), 32'd1);
    bus.y_ready_i = 1'b1;
    chk("bp_y", held, (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEADBEEF);
    send(32'h3F800000, 2, horner(32'h3F800000, 2));
    chk("bp_next_accept", 32'(busy_o), 32'd1);
    finish_sample("bp_second");

    // reset during WAIT; the late MAC result must be ignored
    cfg_order(15);
    send(32'h3F800000, 15, horner(32'h3F800000, 15));
    g = 0;
    while (req_cnt == reqs0 && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    @(negedge clk_i);
    rstn_i = 1'b0;
    @(negedge clk_i);
    ok = (bus.x_ready_o === 1'b1) && (busy_o === 1'b0) && (bus.y_valid_o === 1'b0) &&
         (bus.y_data_o === '0) && (bus.mac_req_o === 1'b0) && (bus.mac_a_o === '0) &&
         (bus.mac_b_o === '0) && (bus.mac_c_o === '0) && (cfg_err_o === 1'b0);
    chk("midrst_outputs", 32'(ok), 32'd1);
    sb_q.delete();
    c_q.delete();
    rstn_i = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (busy_o !== 1'b0 || bus.y_valid_o !== 1'b0 || bus.mac_req_o !== 1'b0) ok = 1'b0;
    end
    chk("midrst_late_ignored", 32'(ok), 32'd1);
    cfg_order(15);
    send(32'h3F800000, 15, horner(32'h3F800000, 15));
    finish_sample("midrst_after");

    // coefficient write while busy is rejected
    cfg_order(3);
    send(32'h3F000000, 3, horner(32'h3F000000, 3));
    @(negedge clk_i);
    chk("rej_busy", 32'(busy_o), 32'd1);
    err0 = err_cnt;
    cfg_we_i = 1'b1; cfg_addr_i = 5'd0; cfg_data_i = 32'h40000000;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    finish_sample("rej_current");
    chk("rej_err_pulses", 32'(err_cnt - err0), 32'd1);
    send(32'h3F000000, 3, horner(32'h3F000000, 3));
    finish_sample("rej_next");
    send(32'h3F800000, 3, horner(32'h3F800000, 3));
    finish_sample("rej_next_x1");

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
